spi_controller: RTL



---
 rtl/spi_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//
// Mode-0 SPI initiator that serialises 16-bit register-write frames
// {rw, addr[6:0], wdata[7:0]} MSB first onto ncs/sclk/copi. It is the
// counterpart of the SPI register peripheral that owns the PWM enable and
// duty-cycle registers.
//
// Frame sequence: IDLE -> SETUP -> SHIFT -> GAP -> IDLE. Every phase lasts
// CLK_DIV clk cycles. A frame keeps busy high for 34*CLK_DIV cycles, and
// done pulses for one cycle on the return to IDLE.
//
// Parameters:
//   CLK_DIV  clk cycles per SCLK half-period, 2..255 (checked at elaboration)
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   start  in   frame request, accepted only in IDLE
//   rw     in   frame bit 15
//   addr   in   frame bits 14:8
//   wdata  in   frame bits 7:0
//   busy   out  high while a frame is in progress
//   done   out  one-cycle pulse on frame completion
//   ncs    out  chip select, active low
//   sclk   out  serial clock, idles low
//   copi   out  serial data, MSB first
//
// All outputs come straight from flops; there is no combinational path
// from any input to a pin.
// ---------------------------------------------------------------------------
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi
);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
      $error("spi_controller: CLK_DIV must be in 2..255");
    end
  endgenerate

  localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        copi_q, copi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        phase_last;

  assign phase_last = (phase_q == PH_LAST);

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic.
  // ncs/busy are derived from the *next* state so that the pin flops change
  // on the same edge as the state register.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (start) begin
          state_d   = ST_SETUP;
          shreg_d   = {rw, addr, wdata};
          bit_cnt_d = 5'd0;
          copi_d    = rw;
        end
      end

      ST_SETUP: begin
        if (phase_last) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;  // first SCLK rise coincides with entering SHIFT
        end
      end

      ST_SHIFT: begin
        if (phase_last) begin
          if (sclk_q) begin
            // Falling edge: count it and present the next bit. The 16th
            // fall does not shift so bit 0 stays on copi for the last low
            // phase.
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q != 5'd15) begin
              shreg_d = {shreg_q[14:0], 1'b0};
              copi_d  = shreg_q[14];
            end
          end else if (bit_cnt_q == 5'd16) begin
            // End of the low phase after the 16th fall.
            state_d = ST_GAP;
            copi_d  = 1'b0;
            shreg_d = 16'h0000;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      ST_GAP: begin
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (phase_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
      end
    endcase

    // Phase counter wraps every CLK_DIV cycles and restarts on every
    // state change; it is held at zero while idle.
    if (state_d != state_q || phase_last || state_q == ST_IDLE) begin
      phase_d = 8'd0;
    end else begin
      phase_d = phase_q + 8'd1;
    end

    ncs_d  = (state_d == ST_IDLE) || (state_d == ST_GAP);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 8'd0;
      bit_cnt_q <= 5'd0;
      shreg_q   <= 16'h0000;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ncs  = ncs_q;
  assign sclk = sclk_q;
  assign copi = copi_q;

endmodule
